// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared definitions for the hazard unit and its multi-cycle scoreboard:
//   - mcState_t : state encoding of the multi-cycle tracker FSM
//   - FWD_*     : operand forward-select codes driven on ForwardxE / ForwardxD
//   - MC_CNT_W  : width of the latency down-counter (covers MC_LAT up to 255)
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_WB   = 2'd2
  } mcState_t;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_W  = 2'b01;  // writeback stage result
  localparam logic [1:0] FWD_M  = 2'b10;  // memory stage result
  localparam logic [1:0] FWD_MC = 2'b11;  // multi-cycle unit result

  localparam int MC_CNT_W = 8;

endpackage

// File: rtl/mc_scoreboard.sv
// ---------------------------------------------------------------------------
// mc_scoreboard
// Tracks the single outstanding multi-cycle (mul/div) operation: a latency
// FSM (IDLE -> BUSY -> WB) plus one pending bit per architectural register.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   McStartE     : multi-cycle op in E issues this cycle (accepted in IDLE only)
//   RdE          : destination of the issuing op
//   pending      : per-register "result not yet written" bits (bit 0 always 0)
//   McIssue      : issue accepted this cycle (IDLE and McStartE)
//   McBusy       : FSM in BUSY or WB
//   McWbValid    : one-cycle writeback pulse (WB state)
//   McWbRd       : destination register of the outstanding op
// ---------------------------------------------------------------------------
module mc_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int MC_LAT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            McStartE,
  input  logic [AW-1:0]   RdE,
  output logic [NREG-1:0] pending,
  output logic            McIssue,
  output logic            McBusy,
  output logic            McWbValid,
  output logic [AW-1:0]   McWbRd
);

  mcState_t              stateReg, stateNext;
  logic [MC_CNT_W-1:0]   cntReg, cntNext;
  logic [AW-1:0]         wbRdReg, wbRdNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= MC_IDLE;
      cntReg   <= '0;
      wbRdReg  <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      wbRdReg  <= wbRdNext;
    end
  end

  // The counter is loaded with MC_LAT-1 on issue and WB is entered on the
  // cycle the decrement would reach zero, so the writeback cycle falls
  // exactly MC_LAT cycles after the issue cycle.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    wbRdNext  = wbRdReg;
    case (stateReg)
      MC_IDLE: begin
        if (McStartE) begin
          stateNext = MC_BUSY;
          cntNext   = MC_CNT_W'(MC_LAT - 1);
          wbRdNext  = RdE;
        end
      end
      MC_BUSY: begin
        if (cntReg <= MC_CNT_W'(1)) begin
          stateNext = MC_WB;
          cntNext   = '0;
        end else begin
          cntNext = cntReg - MC_CNT_W'(1);
        end
      end
      MC_WB: begin
        stateNext = MC_IDLE;
      end
      default: begin
        stateNext = MC_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  assign McIssue   = (stateReg == MC_IDLE) && McStartE;
  assign McBusy    = (stateReg == MC_BUSY) || (stateReg == MC_WB);
  assign McWbValid = (stateReg == MC_WB);
  assign McWbRd    = wbRdReg;

  // Register 0 is hardwired and never waits on anything.
  assign pending[0] = 1'b0;

  // Set and clear can never coincide: issue happens only in IDLE and the
  // clear only in WB.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_pend
      logic bitReg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bitReg <= 1'b0;
        end else if (McIssue && (RdE == AW'(gi))) begin
          bitReg <= 1'b1;
        end else if (McWbValid && (wbRdReg == AW'(gi))) begin
          bitReg <= 1'b0;
        end
      end
      assign pending[gi] = bitReg;
    end
  endgenerate

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Pipeline hazard unit: operand forwarding for E and D, load-use and
// multi-cycle scoreboard stalls, redirect flushes and a stall-cycle counter.
//
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   Rs1D, Rs2D, Rs1E, Rs2E      : source registers in D and E
//   RdE, RdM, RdW               : destination registers in E, M, W
//   RegWriteM, RegWriteW        : register write enables in M and W
//   LoadE                       : E holds a load
//   McOpD                       : D holds a multi-cycle op
//   McStartE                    : multi-cycle op issues from E this cycle
//   PCRedirectE                 : taken branch/jump resolved in E
//   ForwardAE, ForwardBE        : E operand select (RF / W / M)
//   ForwardAD, ForwardBD        : D operand select (RF / W / M / MC)
//   StallF, StallD, FlushD, FlushE : pipeline control
//   McBusy, McWbValid, McWbRd   : multi-cycle unit status / writeback port
//   StallCnt                    : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int MC_LAT = 8,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] Rs1D,
  input  logic [AW-1:0] Rs2D,
  input  logic [AW-1:0] Rs1E,
  input  logic [AW-1:0] Rs2E,
  input  logic [AW-1:0] RdE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          LoadE,
  input  logic          McOpD,
  input  logic          McStartE,
  input  logic          PCRedirectE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic [1:0]    ForwardAD,
  output logic [1:0]    ForwardBD,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          FlushE,
  output logic          McBusy,
  output logic          McWbValid,
  output logic [AW-1:0] McWbRd,
  output logic [CW-1:0] StallCnt
);

  logic [NREG-1:0] pending;
  logic            mcIssue;
  logic            lwStall;
  logic            sbStall;
  logic            stallAny;
  logic [3:0]      fwdEVec;
  logic [3:0]      fwdDVec;
  logic [1:0]      pendHitVec;
  logic [AW-1:0]   srcE [2];
  logic [AW-1:0]   srcD [2];
  logic [CW-1:0]   stallCntReg;

  mc_scoreboard #(
    .NREG   (NREG),
    .AW     (AW),
    .MC_LAT (MC_LAT)
  ) u_mc_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .McStartE  (McStartE),
    .RdE       (RdE),
    .pending   (pending),
    .McIssue   (mcIssue),
    .McBusy    (McBusy),
    .McWbValid (McWbValid),
    .McWbRd    (McWbRd)
  );

  assign srcE[0] = Rs1E;
  assign srcE[1] = Rs2E;
  assign srcD[0] = Rs1D;
  assign srcD[1] = Rs2D;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [1:0] fwdE;
      logic [1:0] fwdD;
      logic       pendHit;

      always_comb begin
        fwdE = FWD_RF;
        if (srcE[gi] != '0) begin
          if (RegWriteM && (RdM == srcE[gi])) begin
            fwdE = FWD_M;
          end else if (RegWriteW && (RdW == srcE[gi])) begin
            fwdE = FWD_W;
          end
        end
      end

      // The multi-cycle writeback port wins over the pipeline stages: it is
      // the only source of that value on the WB cycle.
      always_comb begin
        fwdD = FWD_RF;
        if (srcD[gi] != '0) begin
          if (McWbValid && (McWbRd == srcD[gi])) begin
            fwdD = FWD_MC;
          end else if (RegWriteM && (RdM == srcD[gi])) begin
            fwdD = FWD_M;
          end else if (RegWriteW && (RdW == srcD[gi])) begin
            fwdD = FWD_W;
          end
        end
      end

      // A pending bit being cleared this cycle is covered by the MC forward,
      // so it does not stall. On the issue cycle the bit is not yet set, but
      // a D-stage reader of the issuing destination must still wait.
      always_comb begin
        pendHit = 1'b0;
        if (pending[srcD[gi]] && !(McWbValid && (McWbRd == srcD[gi]))) begin
          pendHit = 1'b1;
        end
        if (mcIssue && (RdE != '0) && (RdE == srcD[gi])) begin
          pendHit = 1'b1;
        end
      end

      assign fwdEVec[gi*2 +: 2] = fwdE;
      assign fwdDVec[gi*2 +: 2] = fwdD;
      assign pendHitVec[gi]     = pendHit;
    end
  endgenerate

  assign ForwardAE = fwdEVec[1:0];
  assign ForwardBE = fwdEVec[3:2];
  assign ForwardAD = fwdDVec[1:0];
  assign ForwardBD = fwdDVec[3:2];

  assign lwStall = LoadE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // A second multi-cycle op in D also waits on the issue cycle of the first;
  // otherwise it would reach E while the unit is BUSY and be dropped.
  assign sbStall = (|pendHitVec) || (McOpD && (McBusy || mcIssue));

  assign stallAny = lwStall || sbStall;
  assign StallF   = stallAny && !PCRedirectE;
  assign StallD   = stallAny && !PCRedirectE;
  assign FlushD   = PCRedirectE;
  assign FlushE   = PCRedirectE || stallAny;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntReg <= '0;
    end else if (StallD && (stallCntReg != '1)) begin
      stallCntReg <= stallCntReg + CW'(1);
    end
  end

  assign StallCnt = stallCntReg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed-vector bench for hazard_scoreboard (MC_LAT=8, CW=5 so that the
// stall counter saturates at 31 within a short run).
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, LoadE, McOpD, McStartE, PCRedirectE;
  logic [1:0]    ForwardAE, ForwardBE, ForwardAD, ForwardBD;
  logic          StallF, StallD, FlushD, FlushE;
  logic          McBusy, McWbValid;
  logic [AW-1:0] McWbRd;
  logic [CW-1:0] StallCnt;

  int vectors    = 0;
  int miscompares = 0;

  hazard_scoreboard #(
    .NREG   (NREG),
    .AW     (AW),
    .MC_LAT (8),
    .CW     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .LoadE       (LoadE),
    .McOpD       (McOpD),
    .McStartE    (McStartE),
    .PCRedirectE (PCRedirectE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .ForwardAD   (ForwardAD),
    .ForwardBD   (ForwardBD),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .McBusy      (McBusy),
    .McWbValid   (McWbValid),
    .McWbRd      (McWbRd),
    .StallCnt    (StallCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0;
    McOpD = 1'b0; McStartE = 1'b0; PCRedirectE = 1'b0;
  endtask

  initial begin
    int sawWb;
    clearInputs();
    rst_n = 1'b0;
    tick();
    tick();

    // Reset state
    #1;
    chk("rst_StallF", 32'(StallF), 32'd0);
    chk("rst_FlushE", 32'(FlushE), 32'd0);
    chk("rst_McBusy", 32'(McBusy), 32'd0);
    chk("rst_McWbValid", 32'(McWbValid), 32'd0);
    chk("rst_McWbRd", 32'(McWbRd), 32'd0);
    chk("rst_StallCnt", 32'(StallCnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    $display("step: reset released");

    // E forwarding: M beats W, r0 never forwards
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
    #1 chk("fwdAE_M_over_W", 32'(ForwardAE), 32'd2);
    Rs1E = 5'd0;
    #1 chk("fwdAE_r0", 32'(ForwardAE), 32'd0);
    Rs2E = 5'd5; RegWriteM = 1'b0;
    #1 chk("fwdBE_W", 32'(ForwardBE), 32'd1);
    Rs1D = 5'd5; RegWriteM = 1'b1;
    #1 chk("fwdAD_M", 32'(ForwardAD), 32'd2);
    $display("step: forwarding vectors");
    clearInputs();
    tick();

    // Load-use stall for one cycle
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    chk("lw_StallF", 32'(StallF), 32'd1);
    chk("lw_StallD", 32'(StallD), 32'd1);
    chk("lw_FlushE", 32'(FlushE), 32'd1);
    chk("lw_FlushD", 32'(FlushD), 32'd0);
    tick();
    clearInputs();
    #1;
    chk("lw_after_StallD", 32'(StallD), 32'd0);
    chk("lw_StallCnt", 32'(StallCnt), 32'd1);
    $display("step: load-use stall");

    // Redirect overrides load-use stall
    LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCRedirectE = 1'b1;
    #1;
    chk("redir_StallF", 32'(StallF), 32'd0);
    chk("redir_StallD", 32'(StallD), 32'd0);
    chk("redir_FlushD", 32'(FlushD), 32'd1);
    chk("redir_FlushE", 32'(FlushE), 32'd1);
    tick();
    clearInputs();
    #1 chk("redir_StallCnt", 32'(StallCnt), 32'd1);
    $display("step: redirect with load-use");

    // Multi-cycle op to r9, dependent reader held in D
    McStartE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
    #1 chk("mc_issue_StallD", 32'(StallD), 32'd1);
    tick();
    McStartE = 1'b0; RdE = 5'd0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("mc_busy%0d_StallD", i), 32'(StallD), 32'd1);
      chk($sformatf("mc_busy%0d_McBusy", i), 32'(McBusy), 32'd1);
      chk($sformatf("mc_busy%0d_WbValid", i), 32'(McWbValid), 32'd0);
      tick();
    end
    #1;
    chk("mc_wb_McWbValid", 32'(McWbValid), 32'd1);
    chk("mc_wb_McWbRd", 32'(McWbRd), 32'd9);
    chk("mc_wb_ForwardAD", 32'(ForwardAD), 32'd3);
    chk("mc_wb_StallD", 32'(StallD), 32'd0);
    chk("mc_wb_McBusy", 32'(McBusy), 32'd1);
    chk("mc_wb_StallCnt", 32'(StallCnt), 32'd9);
    tick();
    #1;
    chk("mc_idle_McBusy", 32'(McBusy), 32'd0);
    chk("mc_idle_McWbValid", 32'(McWbValid), 32'd0);
    chk("mc_idle_StallD", 32'(StallD), 32'd0);
    chk("mc_idle_ForwardAD", 32'(ForwardAD), 32'd0);
    $display("step: multi-cycle op r9");
    clearInputs();

    // Back-to-back multi-cycle ops: second waits in D through WB
    McStartE = 1'b1; RdE = 5'd3;
    #1 chk("mc2_issue_StallD", 32'(StallD), 32'd0);
    tick();
    McStartE = 1'b0; RdE = 5'd0; McOpD = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1 chk($sformatf("mc2_busy%0d_StallD", i), 32'(StallD), 32'd1);
      tick();
    end
    #1;
    chk("mc2_wb_McWbValid", 32'(McWbValid), 32'd1);
    chk("mc2_wb_StallD", 32'(StallD), 32'd1);
    tick();
    McOpD = 1'b0; McStartE = 1'b1; RdE = 5'd4;
    #1;
    chk("mc2_next_McBusy", 32'(McBusy), 32'd0);
    chk("mc2_next_StallD", 32'(StallD), 32'd0);
    chk("mc2_next_StallCnt", 32'(StallCnt), 32'd17);
    tick();
    #1;
    chk("mc3_McBusy", 32'(McBusy), 32'd1);
    chk("mc3_McWbRd", 32'(McWbRd), 32'd4);
    $display("step: back-to-back multi-cycle ops");

    // Issue attempt while BUSY is ignored
    RdE = 5'd6;
    tick();
    McStartE = 1'b0; RdE = 5'd0; Rs1D = 5'd6;
    #1 chk("ignored_issue_StallD", 32'(StallD), 32'd0);
    chk("ignored_issue_McWbRd", 32'(McWbRd), 32'd4);
    Rs1D = 5'd4;
    #1 chk("busy_r4_StallD", 32'(StallD), 32'd1);
    $display("step: ignored issue while busy");

    // Asynchronous reset mid-BUSY
    #1 rst_n = 1'b0;
    #1;
    chk("rstbusy_McBusy", 32'(McBusy), 32'd0);
    chk("rstbusy_StallD", 32'(StallD), 32'd0);
    chk("rstbusy_StallCnt", 32'(StallCnt), 32'd0);
    tick();
    rst_n = 1'b1;
    sawWb = 0;
    for (int i = 0; i < 12; i++) begin
      #1 if (McWbValid) sawWb = 1;
      tick();
    end
    chk("rstbusy_no_wb", 32'(sawWb), 32'd0);
    chk("rstbusy_r4_StallD", 32'(StallD), 32'd0);
    $display("step: reset during busy");
    clearInputs();

    // Stall counter saturation (CW=5 -> 31)
    LoadE = 1'b1; RdE = 5'd2; Rs1D = 5'd2;
    for (int i = 0; i < 35; i++) tick();
    #1 chk("sat_StallCnt", 32'(StallCnt), 32'd31);
    clearInputs();
    tick();
    #1 chk("sat_hold_StallCnt", 32'(StallCnt), 32'd31);
    $display("step: stall counter saturation");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
